// File: rtl/pingpong_subblk_writer_pkg.sv
// Shared types and helpers for the ping-pong sub-block writer.
package pingpong_subblk_writer_pkg;

    localparam int          STALL_CNT_W   = 16;
    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    // Bank bookkeeping that must move together on every edge.
    typedef struct packed {
        logic       wbank;
        logic       rd_sel;
        logic [1:0] bank_full;
    } ctrl_t;

    function automatic logic [STALL_CNT_W-1:0] stall_sat_inc(input logic [STALL_CNT_W-1:0] cnt);
        if (cnt == STALL_CNT_MAX) begin
            return cnt;
        end else begin
            return cnt + 16'd1;
        end
    endfunction

endpackage

// File: rtl/macro_para.sv
// Shared build-wide widths: sub-block data width and sub-blocks per ping-pong bank.
// Writer and reader both take their bank geometry from here.
`ifndef SUB_BLK_BIT
`define SUB_BLK_BIT 8
`endif
`ifndef PP_BLK_SUBBLKS
`define PP_BLK_SUBBLKS 8
`endif

// File: rtl/pingpong_subblk_writer.sv
// Write-side controller for the ping-pong sub-block buffer: fills bank 0/1 in turn,
// tracks full flags, and steers rd_sel on consumer releases. Optional PP_STALL_CNT_EN adds stall_cnt.
`ifndef SUB_BLK_BIT
`define SUB_BLK_BIT 8
`endif
`ifndef PP_BLK_SUBBLKS
`define PP_BLK_SUBBLKS 8
`endif

module pingpong_subblk_writer
    import pingpong_subblk_writer_pkg::*;
#(
    parameter int SUB_BLK_BIT = `SUB_BLK_BIT,
    parameter int BLK_SUBBLKS = `PP_BLK_SUBBLKS,
    parameter int ADDR_W      = $clog2(BLK_SUBBLKS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [SUB_BLK_BIT-1:0] in_data,
    output logic                   in_ready,
    output logic                   wr_en0,
    output logic                   wr_en1,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [SUB_BLK_BIT-1:0] wr_data,
    output logic [1:0]             bank_full,
    input  logic [1:0]             bank_release,
    output logic                   rd_sel
`ifdef PP_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    localparam logic [ADDR_W-1:0] WADDR_LAST = ADDR_W'(BLK_SUBBLKS - 1);

    ctrl_t                  ctrl_r;
    ctrl_t                  ctrl_s;
    logic [ADDR_W-1:0]      waddr_r;
    logic [ADDR_W-1:0]      waddr_s;
    logic [ADDR_W-1:0]      wr_addr_r;
    logic [ADDR_W-1:0]      wr_addr_s;
    logic [SUB_BLK_BIT-1:0] wr_data_r;
    logic [SUB_BLK_BIT-1:0] wr_data_s;
    logic [1:0]             wr_en_r;
    logic [1:0]             wr_en_s;
    logic                   in_ready_s;
    logic                   accept_s;
    logic                   release_hit_s;

    // State register: all write/read-side bookkeeping and the registered write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_r    <= '{wbank: 1'b0, rd_sel: 1'b0, bank_full: 2'b00};
            waddr_r   <= '0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
            wr_en_r   <= 2'b00;
        end else begin
            ctrl_r    <= ctrl_s;
            waddr_r   <= waddr_s;
            wr_addr_r <= wr_addr_s;
            wr_data_r <= wr_data_s;
            wr_en_r   <= wr_en_s;
        end
    end

    // Next state: a write accept and a release may land in the same cycle; they
    // always touch different banks because a full bank never accepts writes.
    always_comb begin
        ctrl_s    = ctrl_r;
        waddr_s   = waddr_r;
        wr_addr_s = wr_addr_r;
        wr_data_s = wr_data_r;
        wr_en_s   = 2'b00;
        if (accept_s) begin
            wr_data_s              = in_data;
            wr_addr_s              = waddr_r;
            wr_en_s[ctrl_r.wbank]  = 1'b1;
            if (waddr_r == WADDR_LAST) begin
                ctrl_s.bank_full[ctrl_r.wbank] = 1'b1;
                ctrl_s.wbank                   = ~ctrl_r.wbank;
                waddr_s                        = '0;
            end else begin
                waddr_s = waddr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end else begin
            wr_en_s = 2'b00;
        end
        if (release_hit_s) begin
            ctrl_s.bank_full[ctrl_r.rd_sel] = 1'b0;
            ctrl_s.rd_sel                   = ~ctrl_r.rd_sel;
        end else begin
            ctrl_s.rd_sel = ctrl_s.rd_sel;
        end
    end

    // Handshake decode from registers only; in_valid never reaches in_ready.
    always_comb begin
        in_ready_s    = ~ctrl_r.bank_full[ctrl_r.wbank];
        accept_s      = in_valid & in_ready_s;
        release_hit_s = bank_release[ctrl_r.rd_sel] & ctrl_r.bank_full[ctrl_r.rd_sel];
    end

    assign in_ready  = in_ready_s;
    assign wr_en0    = wr_en_r[0];
    assign wr_en1    = wr_en_r[1];
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign bank_full = ctrl_r.bank_full;
    assign rd_sel    = ctrl_r.rd_sel;

`ifdef PP_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_r;

    // Saturating count of cycles where upstream offers data but every bank is full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= '0;
        end else if (in_valid & ~in_ready_s) begin
            stall_cnt_r <= stall_sat_inc(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_pingpong_subblk_writer.sv
// Directed bench for pingpong_subblk_writer: per-bank fill-count model plus literal spot checks.
`ifndef SUB_BLK_BIT
`define SUB_BLK_BIT 8
`endif
`ifndef PP_BLK_SUBBLKS
`define PP_BLK_SUBBLKS 8
`endif

module tb_pingpong_subblk_writer;

    localparam int DW = `SUB_BLK_BIT;
    localparam int N  = `PP_BLK_SUBBLKS;
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          wr_en0;
    logic          wr_en1;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [1:0]    bank_full;
    logic [1:0]    bank_release = 2'b00;
    logic          rd_sel;
`ifdef PP_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    pingpong_subblk_writer dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .wr_en0       (wr_en0),
        .wr_en1       (wr_en1),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .bank_full    (bank_full),
        .bank_release (bank_release),
        .rd_sel       (rd_sel)
`ifdef PP_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Model: each bank is just a count of sub-blocks written (N = full).
    int      m_cnt0, m_cnt1, m_stall;
    bit      m_wbank, m_rdsel;
    bit      e_en0, e_en1;
    int      e_addr;
    logic [DW-1:0] e_data;
    logic    m_ready, m_acc, m_rel;
    int      m_fill;

    always_comb begin
        m_fill  = m_wbank ? m_cnt1 : m_cnt0;
        m_ready = (m_fill < N);
        m_acc   = in_valid && m_ready;
        m_rel   = m_rdsel ? (bank_release[1] && m_cnt1 == N) : (bank_release[0] && m_cnt0 == N);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt0 <= 0; m_cnt1 <= 0; m_stall <= 0;
            m_wbank <= 1'b0; m_rdsel <= 1'b0;
            e_en0 <= 1'b0; e_en1 <= 1'b0; e_addr <= 0; e_data <= '0;
        end else begin
            e_en0 <= m_acc && !m_wbank;
            e_en1 <= m_acc && m_wbank;
            if (m_acc) begin
                e_addr <= m_fill;
                e_data <= in_data;
            end
            if (m_acc && !m_wbank) m_cnt0 <= m_cnt0 + 1;
            else if (m_rel && !m_rdsel) m_cnt0 <= 0;
            if (m_acc && m_wbank) m_cnt1 <= m_cnt1 + 1;
            else if (m_rel && m_rdsel) m_cnt1 <= 0;
            if (m_acc && m_fill == N - 1) m_wbank <= !m_wbank;
            if (m_rel) m_rdsel <= !m_rdsel;
            if (in_valid && !m_ready && m_stall < 65535) m_stall <= m_stall + 1;
        end
    end

    // Compare process: outputs are stable mid-cycle, away from the active edge.
    always @(negedge clk) begin
        chk("in_ready",  32'(in_ready),  32'(m_ready));
        chk("wr_en0",    32'(wr_en0),    32'(e_en0));
        chk("wr_en1",    32'(wr_en1),    32'(e_en1));
        chk("wr_addr",   32'(wr_addr),   32'(e_addr));
        chk("wr_data",   32'(wr_data),   32'(e_data));
        chk("bank_full", 32'(bank_full), {30'd0, m_cnt1 == N, m_cnt0 == N});
        chk("rd_sel",    32'(rd_sel),    32'(m_rdsel));
`ifdef PP_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    end

    // Drive one cycle of inputs; returns mid-cycle after the edge that sampled them.
    task automatic step(input logic v, input int d, input logic [1:0] rel);
        in_valid     = v;
        in_data      = DW'(d);
        bank_release = rel;
        @(negedge clk);
        #1;
    endtask

    initial begin
        @(negedge clk); #1;
        @(negedge clk); #1;
        reset = 1'b0;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_bank_full", 32'(bank_full), 32'd0);
        chk("rst_wr_en",     32'({wr_en1, wr_en0}), 32'd0);

        // Releases to the non-rd_sel bank and to a free bank are ignored.
        step(1'b0, 0, 2'b10);
        step(1'b0, 0, 2'b01);
        chk("ign_bank_full", 32'(bank_full), 32'd0);
        chk("ign_rd_sel",    32'(rd_sel),    32'd0);

        for (int i = 1; i <= 2 * N; i++) begin
            step(1'b1, i, 2'b00);
            if (i == 1) chk("first_addr", 32'(wr_addr), 32'd0);
            if (i == N) begin
                chk("b0_last_full", 32'(bank_full), 32'd1);
                chk("b0_last_addr", 32'(wr_addr),   32'(N - 1));
                chk("b0_last_en0",  32'(wr_en0),    32'd1);
            end
            if (i == N + 1) begin
                chk("b1_first_en1",  32'(wr_en1),  32'd1);
                chk("b1_first_addr", 32'(wr_addr), 32'd0);
                chk("b1_first_data", 32'(wr_data), 32'(N + 1));
            end
        end
        chk("both_full",  32'(bank_full), 32'd3);
        chk("both_ready", 32'(in_ready),  32'd0);

        for (int i = 0; i < 10; i++) step(1'b1, 8'hAA, 2'b00);
        chk("stall_no_en", 32'({wr_en1, wr_en0}), 32'd0);
`ifdef PP_STALL_CNT_EN
        chk("stall_cnt10", 32'(stall_cnt), 32'd10);
`endif

        step(1'b1, 8'h55, 2'b01);
        chk("rel0_full",  32'(bank_full), 32'd2);
        chk("rel0_rdsel", 32'(rd_sel),    32'd1);
        chk("rel0_ready", 32'(in_ready),  32'd1);
        step(1'b1, 8'h56, 2'b00);
        chk("rel0_wr_en0", 32'(wr_en0),  32'd1);
        chk("rel0_addr",   32'(wr_addr), 32'd0);
        chk("rel0_data",   32'(wr_data), 32'h56);

        step(1'b0, 0, 2'b01);
        chk("ign2_full", 32'(bank_full), 32'd2);
        step(1'b0, 0, 2'b11);
        chk("both_bits_full",  32'(bank_full), 32'd0);
        chk("both_bits_rdsel", 32'(rd_sel),    32'd0);

        // Complete bank 0, then make the last bank-1 write coincide with releasing bank 0.
        for (int i = 1; i < N; i++) step(1'b1, 8'h60 + i, 2'b00);
        for (int i = 0; i < N - 1; i++) step(1'b1, 8'h80 + i, 2'b00);
        step(1'b1, 8'h90, 2'b01);
        chk("coinc_full",  32'(bank_full), 32'd2);
        chk("coinc_rdsel", 32'(rd_sel),    32'd1);
        chk("coinc_ready", 32'(in_ready),  32'd1);
        chk("coinc_en1",   32'(wr_en1),    32'd1);

        step(1'b0, 0, 2'b10);
        for (int i = 0; i < N + 3; i++) step(1'b1, 8'hA0 + i, 2'b00);
        chk("pre_rst_addr", 32'(wr_addr), 32'd2);

        // Asynchronous reset mid-cycle must clear outputs without waiting for an edge.
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("arst_en",    32'({wr_en1, wr_en0}), 32'd0);
        chk("arst_addr",  32'(wr_addr),   32'd0);
        chk("arst_data",  32'(wr_data),   32'd0);
        chk("arst_full",  32'(bank_full), 32'd0);
        chk("arst_rdsel", 32'(rd_sel),    32'd0);
        chk("arst_ready", 32'(in_ready),  32'd1);
        @(negedge clk); #1;
        reset = 1'b0;
        step(1'b1, 8'h77, 2'b00);
        chk("post_rst_en0",  32'(wr_en0),  32'd1);
        chk("post_rst_addr", 32'(wr_addr), 32'd0);
        chk("post_rst_data", 32'(wr_data), 32'h77);
        step(1'b0, 0, 2'b00);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
